// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// FSM state encoding and small operation-class helpers.
package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
  localparam logic [2:0] OP_MSUBU = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MUL    = 3'd1,
    ST_DIV    = 3'd2,
    ST_FIX    = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  function automatic logic is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_acc(input logic [2:0] op);
    return !((op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU));
  endfunction

  function automatic logic is_sub(input logic [2:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// Shared iterative datapath: radix-2 shift-add multiply and restoring divide
// on magnitudes. partial holds {hi,lo}: product, or {remainder,quotient}.
module hilo_iter_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               div_mode,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] partial,
  output logic               last
);

  logic [WIDTH-1:0]   opb_q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [2*WIDTH-1:0] next_partial;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // One iteration step: add-and-shift-right for multiply, shift-left and
  // trial-subtract for divide. The remainder invariant keeps diff in WIDTH bits.
  always_comb begin
    mul_sum = {1'b0, partial[2*WIDTH-1:WIDTH]};
    if (partial[0])
      mul_sum = {1'b0, partial[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    trial = {partial[2*WIDTH-1:WIDTH], partial[WIDTH-1]};
    ge    = (trial >= {1'b0, opb_q});
    diff  = trial[WIDTH-1:0] - opb_q;
    if (div_mode) begin
      if (ge)
        next_partial = {diff, partial[WIDTH-2:0], 1'b1};
      else
        next_partial = {trial[WIDTH-1:0], partial[WIDTH-2:0], 1'b0};
    end else begin
      next_partial = {mul_sum, partial[WIDTH-1:1]};
    end
  end

  // Datapath registers: load the operands, then advance one step per cycle.
  always_ff @(posedge clk) begin
    if (load) begin
      partial <= {{WIDTH{1'b0}}, op_a};
      opb_q   <= op_b;
    end else if (step) begin
      partial <= next_partial;
    end
  end

  // Iteration counter; last flags the final step of a WIDTH-step run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= '0;
    else if (step)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO architectural registers with an iterative multiply/divide engine.
// Optional macro HILO_FAST_MUL_EN: single-cycle combinational multiply
// (multiply-class Start-to-Done latency of 3); divide stays iterative.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             Flush,
  input  logic             WriteEnHi,
  input  logic             WriteEnLo,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] ReadHi,
  output logic [WIDTH-1:0] ReadLo
);

  state_e             state;
  logic [2:0]         op_q;
  logic               neg_res;
  logic               neg_rem;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [2*WIDTH-1:0] res;
  logic [2*WIDTH-1:0] fix_val;
  logic [2*WIDTH-1:0] commit_val;
  logic [2*WIDTH-1:0] core_partial;
  logic [2*WIDTH-1:0] mul_mag;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               accept;
  logic               core_step;
  logic               core_last;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  assign ReadHi = hi_q;
  assign ReadLo = lo_q;
  assign accept = (state == ST_IDLE) && Start && !Flush;
  assign a_in   = magnitude(OpA, is_signed(Op));
  assign b_in   = magnitude(OpB, is_signed(Op));

`ifdef HILO_FAST_MUL_EN
  logic [WIDTH-1:0]   a_mag_q;
  logic [WIDTH-1:0]   b_mag_q;
  logic [2*WIDTH-1:0] fast_prod;
  assign core_step = (state == ST_DIV);
  assign mul_mag   = fast_prod;

  // Full-width multiply of the latched magnitudes, taken in the MUL cycle.
  always_ff @(posedge Clk) begin
    if (accept) begin
      a_mag_q <= a_in;
      b_mag_q <= b_in;
    end
    if (state == ST_MUL)
      fast_prod <= (2*WIDTH)'(a_mag_q) * (2*WIDTH)'(b_mag_q);
  end
`else
  assign core_step = (state == ST_MUL) || (state == ST_DIV);
  assign mul_mag   = core_partial;
`endif

  hilo_iter_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .load     (accept),
    .step     (core_step),
    .div_mode (is_div(op_q)),
    .op_a     (a_in),
    .op_b     (b_in),
    .partial  (core_partial),
    .last     (core_last)
  );

  // Sign fix-up of the magnitude result, and the value written at COMMIT.
  always_comb begin
    if (is_div(op_q))
      fix_val = {neg_if(core_partial[2*WIDTH-1:WIDTH], neg_rem),
                 neg_if(core_partial[WIDTH-1:0], neg_res)};
    else
      fix_val = neg2_if(mul_mag, neg_res);
    commit_val = res;
    if (is_acc(op_q)) begin
      if (is_sub(op_q))
        commit_val = {hi_q, lo_q} - res;
      else
        commit_val = {hi_q, lo_q} + res;
    end
  end

  // Result register: divide-by-zero value at accept, signed result in FIX.
  always_ff @(posedge Clk) begin
    if (accept)
      res <= {OpA, {WIDTH{1'b1}}};
    else if (state == ST_FIX)
      res <= fix_val;
  end

  // Control FSM with registered Busy/Done/DivZero and the HI/LO registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= ST_IDLE;
      op_q    <= OP_MULT;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      if (state != ST_IDLE && Flush) begin
        state <= ST_IDLE;
        Busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (WriteEnHi) hi_q <= WriteData;
            if (WriteEnLo) lo_q <= WriteData;
            if (accept) begin
              op_q    <= Op;
              neg_res <= is_signed(Op) && (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
              neg_rem <= is_signed(Op) && OpA[WIDTH-1];
              Busy    <= 1'b1;
              if (is_div(Op) && (OpB == '0)) begin
                state   <= ST_COMMIT;
                Done    <= 1'b1;
                DivZero <= 1'b1;
              end else if (is_div(Op)) begin
                state <= ST_DIV;
              end else begin
                state <= ST_MUL;
              end
            end
          end
          ST_MUL: begin
`ifdef HILO_FAST_MUL_EN
            state <= ST_FIX;
`else
            if (core_last) state <= ST_FIX;
`endif
          end
          ST_DIV: begin
            if (core_last) state <= ST_FIX;
          end
          ST_FIX: begin
            state <= ST_COMMIT;
            Done  <= 1'b1;
          end
          ST_COMMIT: begin
            hi_q  <= commit_val[2*WIDTH-1:WIDTH];
            lo_q  <= commit_val[WIDTH-1:0];
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
